// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 Set-2 scan codes to ASCII with modifier tracking,
// typematic repeat filtering and a show-ahead output FIFO.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH    = 8,
    parameter int CNT_WIDTH     = 8,
    parameter int REPEAT_FILTER = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           code_in,
    input  logic                 code_valid,
    output logic [7:0]           ascii_data,
    output logic                 ascii_valid,
    input  logic                 ascii_ready,
    output logic                 shift_on,
    output logic                 ctrl_on,
    output logic                 caps_on,
    output logic [CNT_WIDTH-1:0] key_count,
    output logic                 overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] LET [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                        8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                        8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                        8'h35, 8'h1A};
    localparam logic [7:0] DIG [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    localparam logic [7:0] DSH [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};
    localparam logic [7:0] SPC [5]  = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    localparam logic [7:0] SPA [5]  = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
    state_t state;
    logic lshift, rshift, lctrl, rctrl, caps_held;
    logic [7:0] last_make;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic mapped, push_req, push_ok, pop, full;
    logic [7:0] ch;

    assign shift_on = lshift | rshift;
    assign ctrl_on  = lctrl | rctrl;

    always_comb begin
        mapped = 1'b0;
        ch = 8'h00;
        for (int i = 0; i < 26; i++)
            if (code_in == LET[i]) begin
                mapped = 1'b1;
                ch = ctrl_on ? 8'(i + 1) : (shift_on ^ caps_on) ? 8'(8'h41 + i) : 8'(8'h61 + i);
            end
        for (int i = 0; i < 10; i++)
            if (code_in == DIG[i]) begin
                mapped = 1'b1;
                ch = shift_on ? DSH[i] : 8'(8'h30 + i);
            end
        for (int i = 0; i < 5; i++)
            if (code_in == SPC[i]) begin
                mapped = 1'b1;
                ch = SPA[i];
            end
    end

    // A repeat of the last mapped make is dropped until that key is released.
    assign push_req    = code_valid && state == IDLE && mapped &&
                         !(REPEAT_FILTER != 0 && code_in == last_make);
    assign ascii_valid = wptr != rptr;
    assign ascii_data  = ascii_valid ? mem[rptr[AW-1:0]] : 8'h00;
    assign pop         = ascii_valid & ascii_ready;
    assign full        = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
    assign push_ok     = push_req && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            lctrl     <= 1'b0;
            rctrl     <= 1'b0;
            caps_on   <= 1'b0;
            caps_held <= 1'b0;
            last_make <= 8'h00;
        end else if (code_valid) begin
            if (code_in == 8'hE0) state <= EXT;
            else if (code_in == 8'hF0) state <= state == IDLE ? BRK : state == EXT ? EXT_BRK : state;
            else begin
                state <= IDLE;
                case (state)
                    IDLE: begin
                        if (code_in == 8'h12) lshift <= 1'b1;
                        if (code_in == 8'h59) rshift <= 1'b1;
                        if (code_in == 8'h14) lctrl <= 1'b1;
                        if (code_in == 8'h58) begin
                            caps_on   <= caps_on ^ ~caps_held;
                            caps_held <= 1'b1;
                        end
                        if (mapped) last_make <= code_in;
                    end
                    BRK: begin
                        if (code_in == 8'h12) lshift <= 1'b0;
                        if (code_in == 8'h59) rshift <= 1'b0;
                        if (code_in == 8'h14) lctrl <= 1'b0;
                        if (code_in == 8'h58) caps_held <= 1'b0;
                        if (code_in == last_make) last_make <= 8'h00;
                    end
                    EXT: if (code_in == 8'h14) rctrl <= 1'b1;
                    default: if (code_in == 8'h14) rctrl <= 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            key_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr      <= wptr + (AW+1)'(1);
                key_count <= key_count + CNT_WIDTH'(1);
            end
            if (push_req && !push_ok) overflow <= 1'b1;
            if (pop) rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk)
        if (push_ok) mem[wptr[AW-1:0]] <= ch;
endmodule
